// File: rtl/alu_mem_pkg.sv
// Shared definitions for the ALU/memory arbiter slice.
//   - state_e       : sequencer FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   - ALU_* / MEM_* : command field encodings understood by the datapath
//   - DEF_*         : default widths and timeout used by alu_mem_arbiter
package alu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_READ  = 2'b10;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_RES_W   = 16;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin arbiter.
//   req_i       : request bits {req1, req0}
//   last_i      : index of the requester served most recently
//   gnt_valid_o : at least one request is present
//   gnt_id_o    : index of the winner (meaningful only with gnt_valid_o)
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        unique case (req_i)
            2'b10:   gnt_id_o = 1'b1;
            // On a tie the requester that was not served last wins.
            2'b11:   gnt_id_o = ~last_i;
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one ALU/memory datapath between
// two valid/ready requesters. Per-requester fields are packed {req1, req0}.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester command handshake
//   req_op, req_mem_op, req_addr, req_a, req_b, req_wdata : command fields
//   rsp_valid           : one-cycle response strobe to the owning requester
//   rsp_result/rsp_error: shared response payload, held until the next response
//   dp_*                : datapath command outputs, start pulse and completion
//   busy                : FSM is not idle
//   grant_id            : owner of the current transaction
module alu_mem_arbiter
    import alu_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RES_W   = DEF_RES_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [3:0]          req_op,
    input  logic [3:0]          req_mem_op,
    input  logic [2*DATA_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [RES_W-1:0]    rsp_result,
    output logic                rsp_error,
    output logic                dp_start,
    output logic [1:0]          dp_op,
    output logic [1:0]          dp_mem_op,
    output logic [DATA_W-1:0]   dp_addr,
    output logic [DATA_W-1:0]   dp_in_a,
    output logic [DATA_W-1:0]   dp_in_b,
    output logic [DATA_W-1:0]   dp_write_data,
    input  logic [RES_W-1:0]    dp_result,
    input  logic                dp_error,
    input  logic                dp_done,
    output logic                busy,
    output logic                grant_id
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [1:0]          mem_op_q, mem_op_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                error_q, error_d;

    logic                arb_valid;
    logic                arb_id;

    rr_arbiter2 u_arb (
        .req_i       (req_valid),
        .last_i      (last_q),
        .gnt_valid_o (arb_valid),
        .gnt_id_o    (arb_id)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mem_op_d  = mem_op_q;
        addr_d    = addr_q;
        a_d       = a_q;
        b_d       = b_q;
        wdata_d   = wdata_q;
        result_d  = result_q;
        error_d   = error_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        dp_start  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Ready is withheld while reset is asserted so nothing is
                // handshaken in a cycle whose state update is discarded.
                if (arb_valid && !rst) begin
                    req_ready[arb_id] = 1'b1;
                    op_d     = arb_id ? req_op[3:2]     : req_op[1:0];
                    mem_op_d = arb_id ? req_mem_op[3:2] : req_mem_op[1:0];
                    addr_d   = arb_id ? req_addr[2*DATA_W-1:DATA_W]  : req_addr[DATA_W-1:0];
                    a_d      = arb_id ? req_a[2*DATA_W-1:DATA_W]     : req_a[DATA_W-1:0];
                    b_d      = arb_id ? req_b[2*DATA_W-1:DATA_W]     : req_b[DATA_W-1:0];
                    wdata_d  = arb_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    grant_d  = arb_id;
                    last_d   = arb_id;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dp_start = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is checked before the terminal count so a done
                // arriving on the last allowed cycle still delivers its data.
                if (dp_done) begin
                    result_d = dp_result;
                    error_d  = dp_error;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the command registers are reset too, so the dp_* outputs they drive are defined from the first cycle.
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            grant_q  <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            mem_op_q <= '0;
            addr_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the values from before the edge.
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mem_op_q <= mem_op_d;
            addr_q   <= addr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign dp_op         = op_q;
    assign dp_mem_op     = mem_op_q;
    assign dp_addr       = addr_q;
    assign dp_in_a       = a_q;
    assign dp_in_b       = b_q;
    assign dp_write_data = wdata_q;
    assign rsp_result    = result_q;
    assign rsp_error     = error_q;
    assign busy          = (state_q != ST_IDLE);
    assign grant_id      = grant_q;

endmodule
